// File: rtl/dac_stream_tx.sv
// AXI-Stream DAC transmitter: saturates filter words to DAC codes, buffers them, emits one beat per pacing tick.
// Optional offset-binary output format selected by defining DAC_OFFSET_BINARY_EN.

// Generic synchronous FIFO with a combinational head read.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: o_full blocks pushes; pushes while full and pops while empty are ignored.
module dac_stream_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push_vld,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push_vld && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// Paced DAC stream transmitter.
// Latency: accepted sample reaches tdata one cycle after the next pacing tick.
// Backpressure: in_ready drops when the FIFO is full; a tick while a beat is pending is counted in miss_cnt.
module dac_stream_tx #(
    parameter int ADC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int IN_WIDTH         = 32,
    parameter int FRAC_SHIFT       = 16,
    parameter int FIFO_DEPTH       = 8,
    parameter int COUNT_WIDTH      = 32,
    parameter int RATE_DIV         = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [AXIS_TDATA_WIDTH-1:0]     M_AXIS_OUT_tdata,
    output logic                            M_AXIS_OUT_tvalid,
    input  logic                            M_AXIS_OUT_tready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     sat_cnt,
    output logic [15:0]                     miss_cnt
);
    localparam int EXT_W = AXIS_TDATA_WIDTH - ADC_WIDTH;
    localparam logic signed [IN_WIDTH-1:0] C_MAX = IN_WIDTH'((1 <<< (ADC_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] C_MIN = IN_WIDTH'(-(1 <<< (ADC_WIDTH - 1)));

    logic [COUNT_WIDTH-1:0]      r_cnt;
    logic [ADC_WIDTH-1:0]        r_held;
    logic                        r_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic [15:0]                 r_sat_cnt;
    logic [15:0]                 r_miss_cnt;

    logic signed [IN_WIDTH-1:0]  w_shifted;
    logic                        w_hi;
    logic                        w_lo;
    logic [ADC_WIDTH-1:0]        w_code;
    logic                        w_accept;
    logic                        w_tick;
    logic                        w_serve;
    logic                        w_miss;
    logic                        w_pop;
    logic [ADC_WIDTH-1:0]        w_head;
    logic [ADC_WIDTH-1:0]        w_next_code;
    logic                        w_full;
    logic                        w_empty;

    function automatic logic [AXIS_TDATA_WIDTH-1:0] fmt_code(input logic [ADC_WIDTH-1:0] c);
`ifdef DAC_OFFSET_BINARY_EN
        return {{EXT_W{1'b0}}, ~c[ADC_WIDTH-1], c[ADC_WIDTH-2:0]};
`else
        return {{EXT_W{c[ADC_WIDTH-1]}}, c};
`endif
    endfunction

    assign w_shifted = $signed(in_data) >>> FRAC_SHIFT;
    assign w_hi      = (w_shifted > C_MAX);
    assign w_lo      = (w_shifted < C_MIN);
    assign w_code    = w_hi ? C_MAX[ADC_WIDTH-1:0] :
                       w_lo ? C_MIN[ADC_WIDTH-1:0] : w_shifted[ADC_WIDTH-1:0];

    assign in_ready  = !w_full;
    assign w_accept  = in_valid && !w_full;

    assign w_tick    = (r_cnt == COUNT_WIDTH'(RATE_DIV - 1));
    assign w_serve   = w_tick && (!r_tvalid || M_AXIS_OUT_tready);
    assign w_miss    = w_tick && r_tvalid && !M_AXIS_OUT_tready;
    assign w_pop     = w_serve && !w_empty;
    // An empty FIFO at a tick repeats the previously emitted code.
    assign w_next_code = w_empty ? r_held : w_head;

    dac_stream_fifo #(
        .W     (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_accept),
        .i_push_dat (w_code),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_level    (fifo_level),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held   <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (w_serve) begin
            r_held   <= w_next_code;
            r_tvalid <= 1'b1;
            r_tdata  <= fmt_code(w_next_code);
        end else if (r_tvalid && M_AXIS_OUT_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept && (w_hi || w_lo) && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign M_AXIS_OUT_tdata  = r_tdata;
    assign M_AXIS_OUT_tvalid = r_tvalid;
    assign sat_cnt           = r_sat_cnt;
    assign miss_cnt          = r_miss_cnt;
endmodule

// File: tb/tb_dac_stream_tx.sv
// Bench for dac_stream_tx: directed scenarios plus random traffic against a queue-based reference model.
module tb_dac_stream_tx;
    localparam int RDIV  = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [3:0]  fifo_level;
    logic [15:0] sat_cnt;
    logic [15:0] miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_cnt;
    int          m_q[$];
    int          m_held;
    bit          m_vld;
    logic [31:0] m_dat;
    int          m_sat;
    int          m_miss;

    always #4 clk = ~clk;

    dac_stream_tx #(.RATE_DIV(RDIV)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .M_AXIS_OUT_tdata  (tdata),
        .M_AXIS_OUT_tvalid (tvalid),
        .M_AXIS_OUT_tready (tready),
        .fifo_level        (fifo_level),
        .sat_cnt           (sat_cnt),
        .miss_cnt          (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input int code);
`ifdef DAC_OFFSET_BINARY_EN
        return 32'(code + 8192);
`else
        return 32'(code);
`endif
    endfunction

    function automatic int conv(input logic [31:0] d, output bit sat);
        int s;
        s = int'(d) >>> 16;
        sat = 1'b0;
        if (s > 8191) begin
            s = 8191;
            sat = 1'b1;
        end else if (s < -8192) begin
            s = -8192;
            sat = 1'b1;
        end
        return s;
    endfunction

    task automatic model_edge();
        bit tick, serve, acc, sat;
        int code;
        if (rst) begin
            m_cnt = 0; m_q.delete(); m_held = 0; m_vld = 0; m_dat = '0; m_sat = 0; m_miss = 0;
            return;
        end
        tick  = (m_cnt == RDIV - 1);
        acc   = in_valid && (m_q.size() < DEPTH);
        serve = tick && (!m_vld || tready);
        if (tick && m_vld && !tready && m_miss < 16'hFFFF) m_miss++;
        if (serve) begin
            if (m_q.size() > 0) m_held = m_q.pop_front();
            m_dat = ext(m_held);
            m_vld = 1;
        end else if (m_vld && tready) begin
            m_vld = 0;
        end
        if (acc) begin
            code = conv(in_data, sat);
            m_q.push_back(code);
            if (sat && m_sat < 16'hFFFF) m_sat++;
        end
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic check_all();
        chk("in_ready",   {31'd0, in_ready}, {31'd0, m_q.size() < DEPTH});
        chk("tvalid",     {31'd0, tvalid},   {31'd0, m_vld});
        chk("tdata",      tdata,             m_dat);
        chk("fifo_level", {28'd0, fifo_level}, 32'(m_q.size()));
        chk("sat_cnt",    {16'd0, sat_cnt},  32'(m_sat));
        chk("miss_cnt",   {16'd0, miss_cnt}, 32'(m_miss));
    endtask

    // One clock: model follows the DUT edge, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_vld();
        bit seen;
        seen = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (tvalid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("tvalid_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'(($urandom_range(0, 16383) - 8192) <<< 16) | 32'($urandom % 65536);
            2: return 32'h7FFF_0000 | 32'($urandom % 65536);
            default: return 32'h8000_0000 | 32'($urandom % 65536);
        endcase
    endfunction

    initial begin
        int first, second, m0, rate;
        logic [31:0] held;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; tready = 1'b1;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        rst = 1'b0;

        // Idle pacing: first pulse 16 cycles after release, then every 16
        first = -1; second = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (tvalid && first < 0) first = k;
            else if (tvalid && second < 0) second = k;
        end
        chk("first_tick", 32'(first), 32'd16);
        chk("tick_period", 32'(second - first), 32'd16);
        chk("idle_miss", {16'd0, miss_cnt}, 32'd0);

        in_valid = 1'b1; in_data = 32'h0005_0000;
        cyc();
        in_valid = 1'b0;
        wait_vld();
        chk("code5", tdata, ext(5));
        wait_vld();
        chk("code5_repeat", tdata, ext(5));

        in_valid = 1'b1; in_data = 32'h7FFF_FFFF;
        cyc();
        in_data = 32'h8000_0000;
        cyc();
        in_valid = 1'b0;
        wait_vld();
        chk("sat_pos", tdata, ext(8191));
        wait_vld();
        chk("sat_neg", tdata, ext(-8192));
        chk("sat_cnt2", {16'd0, sat_cnt}, 32'd2);

        // Fill to full
        in_valid = 1'b1;
        for (int i = 0; i < 20 && in_ready; i++) begin
            in_data = rand_data();
            cyc();
        end
        in_valid = 1'b0;
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        chk("full_ready", {31'd0, in_ready}, 32'd0);

        // Stall across three ticks
        for (int i = 0; i < 40 && tvalid; i++) cyc();
        m0 = miss_cnt;
        tready = 1'b0;
        held = '0;
        for (int i = 0; i < 3 * RDIV; i++) begin
            cyc();
            if (tvalid && held == '0) held = tdata;
        end
        chk("stall_miss", 32'(miss_cnt) - 32'(m0), 32'd2);
        chk("stall_tvalid", {31'd0, tvalid}, 32'd1);
        chk("stall_hold", tdata, held);

        // Reset aborts the pending beat
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_tvalid", {31'd0, tvalid}, 32'd0);
        chk("abort_level", {28'd0, fifo_level}, 32'd0);
        chk("abort_cnts", {sat_cnt, miss_cnt}, 32'd0);
        tready = 1'b1;

        // Random traffic in segments with varying input rate
        for (int seg = 0; seg < 6; seg++) begin
            rate = 2 + seg * 5;
            for (int i = 0; i < 500; i++) begin
                in_valid = ($urandom % rate) == 0;
                in_data  = rand_data();
                tready   = (seg % 2) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
                rst      = ($urandom % 700) == 0;
                cyc();
            end
        end
        rst = 1'b0; in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
